// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-side bundle (stall/branch/jump in, pc/pc_seq/pc_valid/halted/misalign out, redirect_cnt with PC_SEQUENCER_STATS_EN); master=fetch control, slave=sequencer
interface pc_sequencer_if #(parameter int WIDTH = 32);
  logic stall, branch_taken, jump;
  logic [WIDTH-1:0] branch_target, jump_target, pc, pc_seq;
  logic pc_valid, halted, misalign;
`ifdef PC_SEQUENCER_STATS_EN
  logic [15:0] redirect_cnt;
  modport master(output stall, branch_taken, branch_target, jump, jump_target,
                 input pc, pc_seq, pc_valid, halted, misalign, redirect_cnt);
  modport slave(input stall, branch_taken, branch_target, jump, jump_target,
                output pc, pc_seq, pc_valid, halted, misalign, redirect_cnt);
`else
  modport master(output stall, branch_taken, branch_target, jump, jump_target,
                 input pc, pc_seq, pc_valid, halted, misalign);
  modport slave(input stall, branch_taken, branch_target, jump, jump_target,
                output pc, pc_seq, pc_valid, halted, misalign);
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: boot/run/halt fetch PC generator (ports clk, rst, bus: stall/branch/jump in, pc/pc_seq/pc_valid/halted/misalign out; PC_SEQUENCER_STATS_EN adds bus.redirect_cnt)
module pc_sequencer #(
  parameter int WIDTH = 32,
  parameter int unsigned STEP = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] END_ADDR = WIDTH'(32764)
) (
  input logic clk,
  input logic rst,
  pc_sequencer_if.slave bus
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LOW = STEP_W - WIDTH'(1);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] pc_r, seq_r, pc_n, seq_n, tgt, cand;
  logic mis_r, mis_n, redir, over, load;
  always_comb begin
    redir = bus.jump | bus.branch_taken;
    tgt = bus.jump ? bus.jump_target : bus.branch_target;
    cand = redir ? tgt & ~LOW : bus.stall ? pc_r : pc_r + STEP_W;
    over = (END_ADDR != '0) && (cand >= END_ADDR);
    load = (state == RUN) && !over;
    state_n = state == BOOT ? RUN : (state == RUN && over) ? HALT : state;
    pc_n = load ? cand : pc_r;
    seq_n = load ? cand + STEP_W : seq_r;
    mis_n = mis_r | ((state == RUN) && redir && ((tgt & LOW) != '0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc_r <= RESET_VECTOR;
      seq_r <= RESET_VECTOR + STEP_W;
      mis_r <= 1'b0;
    end else begin
      state <= state_n;
      pc_r <= pc_n;
      seq_r <= seq_n;
      mis_r <= mis_n;
    end
  end
  assign bus.pc = pc_r;
  assign bus.pc_seq = seq_r;
  assign bus.pc_valid = state == RUN;
  assign bus.halted = state == HALT;
  assign bus.misalign = mis_r;
`ifdef PC_SEQUENCER_STATS_EN
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load && redir && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign bus.redirect_cnt = cnt;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed check of pc_sequencer against a behavioural model
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pc_sequencer_if #(.WIDTH(32)) bus();
  pc_sequencer dut(.clk(clk), .rst(rst), .bus(bus));
  int assertions = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [31:0] m_pc;
  int m_ph;
  bit m_mis;
  int m_cnt;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin : model
    logic [31:0] c;
    bit r;
    if (rst) begin
      m_pc = 32'd0;
      m_ph = 0;
      m_mis = 1'b0;
      m_cnt = 0;
    end else if (m_ph == 0) begin
      m_ph = 1;
    end else if (m_ph == 1) begin
      r = bus.jump || bus.branch_taken;
      c = bus.jump ? bus.jump_target : bus.branch_taken ? bus.branch_target : bus.stall ? m_pc : m_pc + 32'd4;
      if (r && (c % 4) != 0) begin
        m_mis = 1'b1;
        c = c - (c % 4);
      end
      if (c >= 32'd32764) m_ph = 2;
      else begin
        m_pc = c;
        if (r && m_cnt < 65535) m_cnt++;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", bus.pc, m_pc);
      check("pc_seq", bus.pc_seq, m_pc + 32'd4);
      check("pc_valid", 32'(bus.pc_valid), 32'(m_ph == 1));
      check("halted", 32'(bus.halted), 32'(m_ph == 2));
      check("misalign", 32'(bus.misalign), 32'(m_mis));
`ifdef PC_SEQUENCER_STATS_EN
      check("redirect_cnt", 32'(bus.redirect_cnt), 32'(m_cnt));
`endif
    end
  end
  task automatic set_in(input bit s, input bit b, input logic [31:0] bt, input bit j, input logic [31:0] jt);
    bus.stall = s;
    bus.branch_taken = b;
    bus.branch_target = bt;
    bus.jump = j;
    bus.jump_target = jt;
  endtask
  function automatic logic [31:0] rnd_tgt();
    int k;
    k = $urandom_range(0, 3);
    return k == 0 ? $urandom : k == 1 ? 32'($urandom_range(32700, 32800)) : 32'($urandom_range(0, 40000));
  endfunction
  initial begin
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pc", bus.pc, 32'd0);
    check("rst_pc_seq", bus.pc_seq, 32'd4);
    check("rst_valid", 32'(bus.pc_valid), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("boot_pc", bus.pc, 32'd0);
    check("boot_valid", 32'(bus.pc_valid), 32'd1);
    @(negedge clk);
    check("seq_pc4", bus.pc, 32'd4);
    @(negedge clk);
    check("seq_pc8", bus.pc, 32'd8);
    check("seq_pc8_seq", bus.pc_seq, 32'd12);
    set_in(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("stall_pc", bus.pc, 32'd8);
    set_in(1, 1, 32'h100, 0, 0);
    @(negedge clk);
    check("branch_over_stall", bus.pc, 32'h100);
    set_in(0, 1, 32'h300, 1, 32'h200);
    @(negedge clk);
    check("jump_over_branch", bus.pc, 32'h200);
    set_in(0, 1, 32'h102, 0, 0);
    @(negedge clk);
    check("misalign_pc", bus.pc, 32'h100);
    check("misalign_set", 32'(bus.misalign), 32'd1);
    set_in(0, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    check("misalign_sticky", 32'(bus.misalign), 32'd1);
    check("misalign_run_pc", bus.pc, 32'h128);
    rst = 1'b1;
    @(negedge clk);
    check("misalign_cleared", 32'(bus.misalign), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    set_in(0, 0, 0, 1, 32'd32760);
    @(negedge clk);
    check("near_end_pc", bus.pc, 32'd32760);
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    check("halt_seq", 32'(bus.halted), 32'd1);
    check("halt_seq_valid", 32'(bus.pc_valid), 32'd0);
    check("halt_seq_pc", bus.pc, 32'd32760);
    set_in(0, 0, 0, 1, 32'd0);
    repeat (3) @(negedge clk);
    check("halt_absorb_pc", bus.pc, 32'd32760);
    check("halt_absorb", 32'(bus.halted), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("halt_rst_pc", bus.pc, 32'd0);
    check("halt_rst_halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 1, 32'h40);
    @(negedge clk);
    check("jump_40", bus.pc, 32'h40);
    set_in(0, 0, 0, 1, 32'd40000);
    @(negedge clk);
    check("halt_redirect", 32'(bus.halted), 32'd1);
    check("halt_redirect_pc", bus.pc, 32'h40);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 32'((i + 1) * 16), 0, 0);
      @(negedge clk);
    end
    set_in(0, 0, 0, 1, 32'h80);
    @(negedge clk);
`ifdef PC_SEQUENCER_STATS_EN
    check("cnt_six", 32'(bus.redirect_cnt), 32'd6);
`endif
    set_in(0, 0, 0, 1, 32'd40000);
    @(negedge clk);
`ifdef PC_SEQUENCER_STATS_EN
    check("cnt_halt_not_counted", 32'(bus.redirect_cnt), 32'd6);
`endif
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef PC_SEQUENCER_STATS_EN
    check("cnt_rst", 32'(bus.redirect_cnt), 32'd0);
`endif
    repeat (4000) begin
      rst = $urandom_range(0, 149) == 0;
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, rnd_tgt(),
             $urandom_range(0, 15) == 0, rnd_tgt());
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
